// File: rtl/wb_stage_pkg.sv
// Shared widths, constants, entry type and helpers for the writeback stage.
package wb_stage_pkg;

    localparam int RegBus     = 32;
    localparam int RegAddrBus = 5;
    localparam int RegNum     = 32;

    localparam logic [RegBus-1:0]     ZeroWord     = '0;
    localparam logic [RegAddrBus-1:0] ZeroReg      = '0;
    localparam logic                  WriteEnable  = 1'b1;
    localparam logic                  WriteDisable = 1'b0;

    // Reset is active-low: RstEnable is the level that holds the block in reset.
    localparam logic RstEnable  = 1'b0;
    localparam logic RstDisable = 1'b1;

    // One buffered ALU result. 'younger' marks a result that must not overtake
    // the outstanding load when both target the same register.
    typedef struct packed {
        logic [RegAddrBus-1:0] rd;
        logic [RegBus-1:0]     data;
        logic                  younger;
    } wb_entry_t;

    // One-hot decode of a register address into a register-file-wide mask.
    function automatic logic [RegNum-1:0] reg_decode(input logic [RegAddrBus-1:0] rd);
        logic [RegNum-1:0] onehot;
        onehot     = '0;
        onehot[rd] = 1'b1;
        return onehot;
    endfunction

endpackage

// File: rtl/wb_stage_fifo.sv
// In-order buffer of ALU results waiting for the register file write port.
// Exposes the head entry, the occupancy and an age-ordered view of every
// entry's destination register so the stage can build its pending mask.
module wb_fifo
    import wb_stage_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push,
    input  wb_entry_t                   push_entry,
    input  logic                        pop,
    input  logic                        clr_younger,
    output wb_entry_t                   head,
    output logic [$clog2(DEPTH):0]      count,
    output logic                        empty,
    output logic [DEPTH*RegAddrBus-1:0] entry_rd,
    output logic [DEPTH-1:0]            entry_valid
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wb_entry_t         mem [DEPTH];
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [CW-1:0]     cnt;
    logic              do_push;
    logic              do_pop;

    // Overflow and underflow requests are dropped so the pointers stay coherent.
    always_comb begin
        do_push = push && (cnt != CW'(DEPTH));
        do_pop  = pop && (cnt != '0);
    end

    // Storage, pointers and occupancy; retiring a load clears every ordering mark.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (clr_younger) begin
                for (int i = 0; i < DEPTH; i++) begin
                    mem[i].younger <= 1'b0;
                end
            end
            if (do_push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Age-ordered flattened view: slot 0 is the head, higher slots are younger.
    always_comb begin
        logic [PW-1:0] slot;
        slot        = '0;
        entry_rd    = '0;
        entry_valid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot                                = rd_ptr + PW'(i);
            entry_rd[i*RegAddrBus +: RegAddrBus] = mem[slot].rd;
            entry_valid[i]                      = (CW'(i) < cnt);
        end
    end

    assign head  = mem[rd_ptr];
    assign count = cnt;
    assign empty = (cnt == '0);

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: arbitrates the register file's single write port between
// the outstanding load (priority) and buffered ALU results, keeps same-register
// write order across the two sources, and publishes a pending-register mask.
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [RegAddrBus-1:0] alu_rd,
    input  logic [RegBus-1:0]     alu_data,
    input  logic                  ld_issue_valid,
    output logic                  ld_issue_ready,
    input  logic [RegAddrBus-1:0] ld_issue_rd,
    input  logic                  ld_resp_valid,
    input  logic [RegBus-1:0]     ld_resp_data,
    output logic                  we,
    output logic [RegAddrBus-1:0] waddr,
    output logic [RegBus-1:0]     wdata,
    output logic [RegNum-1:0]     pending,
    output logic                  ld_busy
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [RegAddrBus-1:0]             ld_rd;
    logic                              ld_accept;
    logic                              ld_retire;
    logic                              alu_push;
    logic                              alu_enq;
    logic                              younger_in;
    logic                              head_blocked;
    logic                              head_pop;
    wb_entry_t                         push_entry;
    wb_entry_t                         head;
    logic [CW-1:0]                     fifo_count;
    logic                              fifo_empty;
    logic [FIFO_DEPTH*RegAddrBus-1:0]  entry_rd;
    logic [FIFO_DEPTH-1:0]             entry_valid;

    // Ready flags come from registered state only, so a same-cycle pop never
    // opens the ALU port early.
    assign alu_ready      = (fifo_count < CW'(FIFO_DEPTH));
    assign ld_issue_ready = !ld_busy;

    // Handshakes, ordering mark for new entries and the write-port choice.
    // A result pushed alongside a retiring load is older than any later load,
    // so it only carries the mark if the load it trails is still outstanding.
    always_comb begin
        ld_accept    = ld_issue_valid && !ld_busy;
        ld_retire    = ld_resp_valid && ld_busy;
        alu_push     = alu_valid && alu_ready;
        alu_enq      = alu_push && (alu_rd != ZeroReg);
        younger_in   = (ld_busy && !ld_retire) || ld_accept;
        push_entry   = '{rd: alu_rd, data: alu_data, younger: younger_in};
        head_blocked = head.younger && ld_busy && (head.rd == ld_rd);
        head_pop     = !fifo_empty && !head_blocked && !ld_retire;
    end

    wb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push        (alu_enq),
        .push_entry  (push_entry),
        .pop         (head_pop),
        .clr_younger (ld_retire),
        .head        (head),
        .count       (fifo_count),
        .empty       (fifo_empty),
        .entry_rd    (entry_rd),
        .entry_valid (entry_valid)
    );

    // Single outstanding load: captured on an accepted issue, dropped on response.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            ld_busy <= 1'b0;
            ld_rd   <= ZeroReg;
        end else if (ld_retire) begin
            ld_busy <= 1'b0;
        end else if (ld_accept) begin
            ld_busy <= 1'b1;
            ld_rd   <= ld_issue_rd;
        end
    end

    // Registered write port: load data first, otherwise the unblocked FIFO head.
    // A load into r0 still retires but produces no write.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            we    <= WriteDisable;
            waddr <= ZeroReg;
            wdata <= ZeroWord;
        end else if (ld_retire) begin
            we    <= (ld_rd != ZeroReg) ? WriteEnable : WriteDisable;
            waddr <= ld_rd;
            wdata <= ld_resp_data;
        end else if (head_pop) begin
            we    <= WriteEnable;
            waddr <= head.rd;
            wdata <= head.data;
        end else begin
            we    <= WriteDisable;
        end
    end

    // Registers still owed a write by the buffer or the outstanding load; r0 never.
    always_comb begin
        pending = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (entry_valid[i]) begin
                pending = pending | reg_decode(entry_rd[i*RegAddrBus +: RegAddrBus]);
            end
        end
        if (ld_busy) begin
            pending = pending | reg_decode(ld_rd);
        end
        pending[0] = 1'b0;
    end

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios with hand-derived
// expectations, then randomized traffic against a queue-based reference model.
module tb_wb_stage;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        ld_issue_valid;
    logic        ld_issue_ready;
    logic [4:0]  ld_issue_rd;
    logic        ld_resp_valid;
    logic [31:0] ld_resp_data;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] pending;
    logic        ld_busy;

    int total = 0;
    int bad   = 0;

    // Reference model: pending ALU writes in program order, each remembering
    // which load (by serial number) it was issued behind.
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        int          waits_on;
    } mentry_t;

    mentry_t     mq[$];
    int          cur_load;
    bit          m_busy;
    logic [4:0]  m_ldrd;
    bit          e_we;
    logic [4:0]  e_waddr;
    logic [31:0] e_wdata;

    wb_stage #(
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .alu_valid      (alu_valid),
        .alu_ready      (alu_ready),
        .alu_rd         (alu_rd),
        .alu_data       (alu_data),
        .ld_issue_valid (ld_issue_valid),
        .ld_issue_ready (ld_issue_ready),
        .ld_issue_rd    (ld_issue_rd),
        .ld_resp_valid  (ld_resp_valid),
        .ld_resp_data   (ld_resp_data),
        .we             (we),
        .waddr          (waddr),
        .wdata          (wdata),
        .pending        (pending),
        .ld_busy        (ld_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        alu_valid      = 1'b0;
        alu_rd         = '0;
        alu_data       = '0;
        ld_issue_valid = 1'b0;
        ld_issue_rd    = '0;
        ld_resp_valid  = 1'b0;
        ld_resp_data   = '0;
    endtask

    task automatic model_clear();
        mq.delete();
        m_busy  = 1'b0;
        m_ldrd  = '0;
        e_we    = 1'b0;
        e_waddr = '0;
        e_wdata = '0;
    endtask

    function automatic logic [31:0] model_pending();
        logic [31:0] p;
        p = '0;
        foreach (mq[i]) p[mq[i].rd] = 1'b1;
        if (m_busy) p[m_ldrd] = 1'b1;
        p[0] = 1'b0;
        return p;
    endfunction

    // Advance one clock: the model consumes the inputs the DUT sees at the edge,
    // then outputs are sampled 1 time unit after the edge.
    task automatic tick();
        bit retire, accept, ready;
        int wait_tag;
        retire   = ld_resp_valid && m_busy;
        accept   = ld_issue_valid && !m_busy;
        ready    = (mq.size() < DEPTH);
        wait_tag = accept ? cur_load + 1 : (m_busy ? cur_load : -1);
        if (retire) begin
            e_we    = (m_ldrd != 0);
            e_waddr = m_ldrd;
            e_wdata = ld_resp_data;
        end else if (mq.size() > 0 &&
                     !(m_busy && mq[0].waits_on == cur_load && mq[0].rd == m_ldrd)) begin
            e_we    = 1'b1;
            e_waddr = mq[0].rd;
            e_wdata = mq[0].data;
            void'(mq.pop_front());
        end else begin
            e_we = 1'b0;
        end
        if (alu_valid && ready && alu_rd != 0)
            mq.push_back('{rd: alu_rd, data: alu_data, waits_on: wait_tag});
        if (retire) begin
            m_busy = 1'b0;
        end else if (accept) begin
            cur_load = cur_load + 1;
            m_busy   = 1'b1;
            m_ldrd   = ld_issue_rd;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle_inputs();
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        total++; if (we !== 1'b0) begin bad++; $display("[TB] FAIL reset_we got=%0b want=0", we); end
        total++; if (waddr !== 5'd0) begin bad++; $display("[TB] FAIL reset_waddr got=%0d want=0", waddr); end
        total++; if (wdata !== 32'd0) begin bad++; $display("[TB] FAIL reset_wdata got=%h want=0", wdata); end
        total++; if (alu_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_alu_ready got=%0b want=1", alu_ready); end
        total++; if (ld_issue_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_ld_issue_ready got=%0b want=1", ld_issue_ready); end
        total++; if (ld_busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_ld_busy got=%0b want=0", ld_busy); end
        total++; if (pending !== 32'd0) begin bad++; $display("[TB] FAIL reset_pending got=%h want=0", pending); end
        rst = 1'b1;
    endtask

    task automatic test_alu_latency();
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h11;
        tick();
        idle_inputs();
        total++; if (pending[5] !== 1'b1) begin bad++; $display("[TB] FAIL alu_pending_c2 got=%0b want=1", pending[5]); end
        total++; if (we !== 1'b0) begin bad++; $display("[TB] FAIL alu_we_c2 got=%0b want=0", we); end
        tick();
        total++; if (we !== 1'b1 || waddr !== 5'd5 || wdata !== 32'h11) begin
            bad++; $display("[TB] FAIL alu_write_c3 got we=%0b a=%0d d=%h want we=1 a=5 d=11", we, waddr, wdata);
        end
        total++; if (pending[5] !== 1'b0) begin bad++; $display("[TB] FAIL alu_pending_c3 got=%0b want=0", pending[5]); end
        tick();
        total++; if (we !== 1'b0) begin bad++; $display("[TB] FAIL alu_we_c4 got=%0b want=0", we); end
    endtask

    task automatic test_waw_load_first();
        ld_issue_valid = 1'b1; ld_issue_rd = 5'd7;
        tick();
        idle_inputs();
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'hAA;
        tick();
        idle_inputs();
        tick();
        tick();
        total++; if (we !== 1'b0) begin bad++; $display("[TB] FAIL waw_early_we got=%0b want=0", we); end
        total++; if (pending[7] !== 1'b1) begin bad++; $display("[TB] FAIL waw_pending_wait got=%0b want=1", pending[7]); end
        ld_resp_valid = 1'b1; ld_resp_data = 32'hBB;
        tick();
        idle_inputs();
        total++; if (we !== 1'b1 || waddr !== 5'd7 || wdata !== 32'hBB) begin
            bad++; $display("[TB] FAIL waw_first got we=%0b a=%0d d=%h want we=1 a=7 d=bb", we, waddr, wdata);
        end
        total++; if (pending[7] !== 1'b1) begin bad++; $display("[TB] FAIL waw_pending_mid got=%0b want=1", pending[7]); end
        tick();
        total++; if (we !== 1'b1 || waddr !== 5'd7 || wdata !== 32'hAA) begin
            bad++; $display("[TB] FAIL waw_second got we=%0b a=%0d d=%h want we=1 a=7 d=aa", we, waddr, wdata);
        end
        total++; if (pending !== 32'd0) begin bad++; $display("[TB] FAIL waw_pending_end got=%h want=0", pending); end
    endtask

    task automatic test_older_alu();
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h01;
        tick();
        idle_inputs();
        ld_issue_valid = 1'b1; ld_issue_rd = 5'd7;
        tick();
        idle_inputs();
        total++; if (we !== 1'b1 || waddr !== 5'd7 || wdata !== 32'h01) begin
            bad++; $display("[TB] FAIL older_write got we=%0b a=%0d d=%h want we=1 a=7 d=1", we, waddr, wdata);
        end
        total++; if (ld_busy !== 1'b1) begin bad++; $display("[TB] FAIL older_busy got=%0b want=1", ld_busy); end
        ld_resp_valid = 1'b1; ld_resp_data = 32'h77;
        tick();
        idle_inputs();
        total++; if (we !== 1'b1 || waddr !== 5'd7 || wdata !== 32'h77) begin
            bad++; $display("[TB] FAIL older_load got we=%0b a=%0d d=%h want we=1 a=7 d=77", we, waddr, wdata);
        end
    endtask

    task automatic test_full_blocked();
        ld_issue_valid = 1'b1; ld_issue_rd = 5'd9;
        tick();
        idle_inputs();
        for (int i = 0; i < DEPTH; i++) begin
            alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h100 + 32'(i);
            tick();
        end
        idle_inputs();
        total++; if (alu_ready !== 1'b0) begin bad++; $display("[TB] FAIL full_ready got=%0b want=0", alu_ready); end
        total++; if (we !== 1'b0) begin bad++; $display("[TB] FAIL full_we got=%0b want=0", we); end
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'hDEAD;
        tick();
        idle_inputs();
        total++; if (alu_ready !== 1'b0) begin bad++; $display("[TB] FAIL full_ready_hold got=%0b want=0", alu_ready); end
        ld_resp_valid = 1'b1; ld_resp_data = 32'h900;
        tick();
        idle_inputs();
        total++; if (we !== 1'b1 || waddr !== 5'd9 || wdata !== 32'h900) begin
            bad++; $display("[TB] FAIL full_load got we=%0b a=%0d d=%h want we=1 a=9 d=900", we, waddr, wdata);
        end
        total++; if (alu_ready !== 1'b0) begin bad++; $display("[TB] FAIL full_ready_pop_cycle got=%0b want=0", alu_ready); end
        for (int i = 0; i < DEPTH; i++) begin
            tick();
            total++; if (we !== 1'b1 || waddr !== 5'd9 || wdata !== 32'h100 + 32'(i)) begin
                bad++; $display("[TB] FAIL full_drain%0d got we=%0b a=%0d d=%h want d=%h", i, we, waddr, wdata, 32'h100 + 32'(i));
            end
            if (i == 0) begin
                total++; if (alu_ready !== 1'b1) begin bad++; $display("[TB] FAIL full_ready_rise got=%0b want=1", alu_ready); end
            end
        end
        tick();
        total++; if (we !== 1'b0) begin bad++; $display("[TB] FAIL full_extra_write got we=%0b d=%h want we=0", we, wdata); end
    endtask

    task automatic test_coincide();
        ld_issue_valid = 1'b1; ld_issue_rd = 5'd4;
        tick();
        idle_inputs();
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h33;
        tick();
        idle_inputs();
        ld_resp_valid = 1'b1; ld_resp_data = 32'h44;
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hBAD0;
        tick();
        idle_inputs();
        total++; if (we !== 1'b1 || waddr !== 5'd4 || wdata !== 32'h44) begin
            bad++; $display("[TB] FAIL coin_load got we=%0b a=%0d d=%h want we=1 a=4 d=44", we, waddr, wdata);
        end
        total++; if (pending !== 32'h8) begin bad++; $display("[TB] FAIL coin_pending got=%h want=8", pending); end
        tick();
        total++; if (we !== 1'b1 || waddr !== 5'd3 || wdata !== 32'h33) begin
            bad++; $display("[TB] FAIL coin_alu got we=%0b a=%0d d=%h want we=1 a=3 d=33", we, waddr, wdata);
        end
        tick();
        total++; if (we !== 1'b0) begin bad++; $display("[TB] FAIL coin_r0_write got we=%0b a=%0d want we=0", we, waddr); end
        total++; if (pending !== 32'd0) begin bad++; $display("[TB] FAIL coin_pending_end got=%h want=0", pending); end
    endtask

    task automatic test_reset_mid();
        ld_issue_valid = 1'b1; ld_issue_rd = 5'd12;
        tick();
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            alu_valid = 1'b1; alu_rd = 5'd12; alu_data = 32'h200 + 32'(i);
            tick();
        end
        idle_inputs();
        total++; if (pending[12] !== 1'b1) begin bad++; $display("[TB] FAIL rmid_pending_before got=%0b want=1", pending[12]); end
        #2;
        rst = 1'b0;
        model_clear();
        #1;
        total++; if (we !== 1'b0 || waddr !== 5'd0 || wdata !== 32'd0) begin
            bad++; $display("[TB] FAIL rmid_port got we=%0b a=%0d d=%h want all 0", we, waddr, wdata);
        end
        total++; if (pending !== 32'd0) begin bad++; $display("[TB] FAIL rmid_pending got=%h want=0", pending); end
        total++; if (ld_busy !== 1'b0 || ld_issue_ready !== 1'b1 || alu_ready !== 1'b1) begin
            bad++; $display("[TB] FAIL rmid_flags got busy=%0b lir=%0b ar=%0b want 0 1 1", ld_busy, ld_issue_ready, alu_ready);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        ld_resp_valid = 1'b1; ld_resp_data = 32'h55;
        tick();
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            total++; if (we !== 1'b0) begin bad++; $display("[TB] FAIL rmid_ghost%0d got we=%0b a=%0d want we=0", i, we, waddr); end
            tick();
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            alu_valid      = ($urandom_range(0, 99) < 60);
            alu_rd         = 5'($urandom_range(0, 7));
            alu_data       = $urandom;
            ld_issue_valid = ($urandom_range(0, 99) < 25);
            ld_issue_rd    = 5'($urandom_range(0, 7));
            ld_resp_valid  = ($urandom_range(0, 99) < 30);
            ld_resp_data   = $urandom;
            tick();
            total++; if (we !== e_we) begin bad++; $display("[TB] FAIL rnd_we c=%0d got=%0b want=%0b", c, we, e_we); end
            if (e_we) begin
                total++; if (waddr !== e_waddr || wdata !== e_wdata) begin
                    bad++; $display("[TB] FAIL rnd_wport c=%0d got a=%0d d=%h want a=%0d d=%h", c, waddr, wdata, e_waddr, e_wdata);
                end
            end
            total++; if (alu_ready !== (mq.size() < DEPTH)) begin bad++; $display("[TB] FAIL rnd_alu_ready c=%0d got=%0b want=%0b", c, alu_ready, mq.size() < DEPTH); end
            total++; if (ld_busy !== m_busy || ld_issue_ready !== !m_busy) begin
                bad++; $display("[TB] FAIL rnd_ld c=%0d got busy=%0b lir=%0b want busy=%0b", c, ld_busy, ld_issue_ready, m_busy);
            end
            total++; if (pending !== model_pending()) begin bad++; $display("[TB] FAIL rnd_pending c=%0d got=%h want=%h", c, pending, model_pending()); end
        end
        idle_inputs();
    endtask

    initial begin
        cur_load = 0;
        idle_inputs();
        test_reset();
        test_alu_latency();
        test_waw_load_first();
        test_older_alu();
        test_full_blocked();
        test_coincide();
        test_reset_mid();
        test_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
